// File: rtl/fetch_decode_queue.sv
// -----------------------------------------------------------------------------
// fetch_decode_queue
//
// Purpose:
//   Fetch-to-decode instruction queue. It holds up to DEPTH fetched entries
//   (PC, instruction, exception flag and exception cause) in a circular buffer,
//   so that a decode stall does not stall fetch straight away. Both sides use
//   valid/ready handshakes. The queue supports a two-level flush and a global
//   pipeline lock.
//
// Optional feature:
//   FD_QUEUE_BYPASS_EN - when defined, a fetch entry that arrives while the
//   queue is empty drives the decode outputs in the same cycle. If the decoder
//   takes it and no lock or flush is active, the entry is never written.
//
// Ports:
//   CLK               in   clock, rising edge
//   RST               in   asynchronous reset, active low
//   lock_PIPELINE     in   global stall: freezes push, pop and FLUSH_P2
//   FLUSH_P1          in   high-priority flush, overrides the lock
//   FLUSH_P2          in   low-priority flush, ignored while locked
//   FETCH_VALID       in   fetch presents an entry
//   FETCH_READY       out  queue not full
//   PC_FROM_FETCH     in   fetch PC
//   INST_FROM_FETCH   in   fetched instruction
//   FETCH_XCPT        in   fetch exception flag
//   FETCH_XCPT_CAUSE  in   fetch exception cause
//   DEC_VALID         out  head entry valid
//   DEC_READY         in   decoder consumes the head
//   PC_TO_DECODE      out  head PC (0 when empty)
//   INST_TO_DECODE    out  head instruction (0 when empty)
//   DEC_XCPT          out  head exception flag (0 when empty)
//   DEC_XCPT_CAUSE    out  head exception cause (0 when empty)
//   OCCUPANCY         out  number of valid entries
// -----------------------------------------------------------------------------
module fetch_decode_queue #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 40,
    parameter int INST_W  = 32,
    parameter int CAUSE_W = 64
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         lock_PIPELINE,
    input  logic                         FLUSH_P1,
    input  logic                         FLUSH_P2,
    input  logic                         FETCH_VALID,
    output logic                         FETCH_READY,
    input  logic [ADDR_W-1:0]            PC_FROM_FETCH,
    input  logic [INST_W-1:0]            INST_FROM_FETCH,
    input  logic                         FETCH_XCPT,
    input  logic [CAUSE_W-1:0]           FETCH_XCPT_CAUSE,
    output logic                         DEC_VALID,
    input  logic                         DEC_READY,
    output logic [ADDR_W-1:0]            PC_TO_DECODE,
    output logic [INST_W-1:0]            INST_TO_DECODE,
    output logic                         DEC_XCPT,
    output logic [CAUSE_W-1:0]           DEC_XCPT_CAUSE,
    output logic [$clog2(DEPTH+1)-1:0]   OCCUPANCY
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [ADDR_W-1:0]  r_pc_mem    [DEPTH];
    logic [INST_W-1:0]  r_inst_mem  [DEPTH];
    logic               r_xcpt_mem  [DEPTH];
    logic [CAUSE_W-1:0] r_cause_mem [DEPTH];

    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_full;
    logic               w_empty;
    logic               w_hold;
    logic               w_push;
    logic               w_pop;
    logic               w_bypass_take;
    logic               w_write;
    logic               w_mem_pop;
    logic [INST_W-1:0]  w_inst_in;

    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_empty     = (r_count == '0);
    assign FETCH_READY = ~w_full;
    assign OCCUPANCY   = r_count;

    // Any lock or flush blocks both handshakes for the cycle.
    assign w_hold    = lock_PIPELINE | FLUSH_P1 | FLUSH_P2;

    // A faulting fetch never forwards its instruction bits.
    assign w_inst_in = FETCH_XCPT ? '0 : INST_FROM_FETCH;

    // Readiness is judged on the current fill level only, so a full queue
    // turns away fetch even when decode drains an entry in the same cycle.
    assign w_push = FETCH_VALID & ~w_full & ~w_hold;
    assign w_pop  = DEC_VALID & DEC_READY & ~w_hold;

`ifdef FD_QUEUE_BYPASS_EN
    assign DEC_VALID     = ~w_empty | FETCH_VALID;
    // A pop while empty can only consume the bypassed fetch entry.
    assign w_bypass_take = w_empty & w_pop;
`else
    assign DEC_VALID     = ~w_empty;
    assign w_bypass_take = 1'b0;
`endif

    assign w_write   = w_push & ~w_bypass_take;
    assign w_mem_pop = w_pop & ~w_empty;

    // Decode view of the head. Zeros when there is nothing valid, so stale
    // array contents never leak out.
    always_comb begin
        PC_TO_DECODE   = '0;
        INST_TO_DECODE = '0;
        DEC_XCPT       = 1'b0;
        DEC_XCPT_CAUSE = '0;
        if (!w_empty) begin
            PC_TO_DECODE   = r_pc_mem[r_rd_ptr];
            INST_TO_DECODE = r_inst_mem[r_rd_ptr];
            DEC_XCPT       = r_xcpt_mem[r_rd_ptr];
            DEC_XCPT_CAUSE = r_cause_mem[r_rd_ptr];
        end
`ifdef FD_QUEUE_BYPASS_EN
        else if (FETCH_VALID) begin
            PC_TO_DECODE   = PC_FROM_FETCH;
            INST_TO_DECODE = w_inst_in;
            DEC_XCPT       = FETCH_XCPT;
            DEC_XCPT_CAUSE = FETCH_XCPT_CAUSE;
        end
`endif
    end

    // Entry storage carries no reset; validity comes from the count alone.
    always_ff @(posedge CLK) begin
        if (w_write) begin
            r_pc_mem[r_wr_ptr]    <= PC_FROM_FETCH;
            r_inst_mem[r_wr_ptr]  <= w_inst_in;
            r_xcpt_mem[r_wr_ptr]  <= FETCH_XCPT;
            r_cause_mem[r_wr_ptr] <= FETCH_XCPT_CAUSE;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (FLUSH_P1) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (lock_PIPELINE) begin
            // Lock freezes everything, including a pending FLUSH_P2.
            r_wr_ptr <= r_wr_ptr;
            r_rd_ptr <= r_rd_ptr;
            r_count  <= r_count;
        end else if (FLUSH_P2) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_mem_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_write && !w_mem_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_write && w_mem_pop) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_decode_queue.sv
module tb_fetch_decode_queue;

    localparam int DEPTH   = 4;
    localparam int ADDR_W  = 40;
    localparam int INST_W  = 32;
    localparam int CAUSE_W = 64;
    localparam int CNT_W   = $clog2(DEPTH+1);

    logic                CLK = 1'b0;
    logic                RST;
    logic                lock_PIPELINE, FLUSH_P1, FLUSH_P2;
    logic                FETCH_VALID, FETCH_READY;
    logic [ADDR_W-1:0]   PC_FROM_FETCH;
    logic [INST_W-1:0]   INST_FROM_FETCH;
    logic                FETCH_XCPT;
    logic [CAUSE_W-1:0]  FETCH_XCPT_CAUSE;
    logic                DEC_VALID, DEC_READY;
    logic [ADDR_W-1:0]   PC_TO_DECODE;
    logic [INST_W-1:0]   INST_TO_DECODE;
    logic                DEC_XCPT;
    logic [CAUSE_W-1:0]  DEC_XCPT_CAUSE;
    logic [CNT_W-1:0]    OCCUPANCY;

    fetch_decode_queue #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .INST_W(INST_W), .CAUSE_W(CAUSE_W)
    ) dut (
        .CLK(CLK), .RST(RST),
        .lock_PIPELINE(lock_PIPELINE), .FLUSH_P1(FLUSH_P1), .FLUSH_P2(FLUSH_P2),
        .FETCH_VALID(FETCH_VALID), .FETCH_READY(FETCH_READY),
        .PC_FROM_FETCH(PC_FROM_FETCH), .INST_FROM_FETCH(INST_FROM_FETCH),
        .FETCH_XCPT(FETCH_XCPT), .FETCH_XCPT_CAUSE(FETCH_XCPT_CAUSE),
        .DEC_VALID(DEC_VALID), .DEC_READY(DEC_READY),
        .PC_TO_DECODE(PC_TO_DECODE), .INST_TO_DECODE(INST_TO_DECODE),
        .DEC_XCPT(DEC_XCPT), .DEC_XCPT_CAUSE(DEC_XCPT_CAUSE),
        .OCCUPANCY(OCCUPANCY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [ADDR_W-1:0]  pc;
        logic [INST_W-1:0]  inst;
        logic               x;
        logic [CAUSE_W-1:0] cause;
    } entry_t;

    entry_t model_q[$];
    int     tests = 0;
    int     fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every decode-side output with the reference queue.
    task automatic chk_all(input string tag);
        entry_t h;
        h.pc = '0; h.inst = '0; h.x = 1'b0; h.cause = '0;
        if (model_q.size() > 0) h = model_q[0];
        chk({tag, ".occ"},   64'(OCCUPANCY),      64'(model_q.size()));
        chk({tag, ".frdy"},  64'(FETCH_READY),    64'(model_q.size() < DEPTH));
        chk({tag, ".dval"},  64'(DEC_VALID),      64'(model_q.size() > 0));
        chk({tag, ".pc"},    64'(PC_TO_DECODE),   64'(h.pc));
        chk({tag, ".inst"},  64'(INST_TO_DECODE), 64'(h.inst));
        chk({tag, ".xcpt"},  64'(DEC_XCPT),       64'(h.x));
        chk({tag, ".cause"}, 64'(DEC_XCPT_CAUSE), h.cause);
    endtask

    // Reference behaviour for one clock edge, from the queue rules.
    task automatic model_edge();
        bit     do_push, do_pop;
        entry_t e;
        if (FLUSH_P1) begin
            model_q.delete();
        end else if (lock_PIPELINE) begin
        end else if (FLUSH_P2) begin
            model_q.delete();
        end else begin
            do_push = FETCH_VALID && (model_q.size() < DEPTH);
            do_pop  = DEC_READY && (model_q.size() > 0);
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                e.pc    = PC_FROM_FETCH;
                e.inst  = FETCH_XCPT ? '0 : INST_FROM_FETCH;
                e.x     = FETCH_XCPT;
                e.cause = FETCH_XCPT_CAUSE;
                model_q.push_back(e);
            end
        end
    endtask

    // Drive one cycle of inputs, clock it, then check after the edge.
    task automatic step(input string tag, input bit lk, input bit f1, input bit f2,
                        input bit fv, input bit dr, input logic [ADDR_W-1:0] pc,
                        input logic [INST_W-1:0] inst, input bit x,
                        input logic [CAUSE_W-1:0] cause);
        lock_PIPELINE    = lk;
        FLUSH_P1         = f1;
        FLUSH_P2         = f2;
        FETCH_VALID      = fv;
        DEC_READY        = dr;
        PC_FROM_FETCH    = pc;
        INST_FROM_FETCH  = inst;
        FETCH_XCPT       = x;
        FETCH_XCPT_CAUSE = cause;
        @(posedge CLK);
        model_edge();
        #1;
        chk_all(tag);
    endtask

    task automatic idle_inputs();
        lock_PIPELINE = 0; FLUSH_P1 = 0; FLUSH_P2 = 0;
        FETCH_VALID = 0; DEC_READY = 0;
        PC_FROM_FETCH = '0; INST_FROM_FETCH = '0;
        FETCH_XCPT = 0; FETCH_XCPT_CAUSE = '0;
    endtask

    initial begin
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] rpc;
        idle_inputs();
        RST = 1'b0;
        #2;
        chk_all("reset");
        chk("reset.frdy_const", 64'(FETCH_READY), 64'd1);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK); #1;

        // 1: single push, visible next cycle
        step("t1", 0,0,0, 1,0, 40'h80000000, 32'h00000013, 0, '0);
        chk("t1.pc_const",   64'(PC_TO_DECODE),   64'h80000000);
        chk("t1.inst_const", 64'(INST_TO_DECODE), 64'h00000013);
        chk("t1.occ_const",  64'(OCCUPANCY),      64'd1);
        step("t1.drain", 0,0,0, 0,1, '0, '0, 0, '0);

        // 2: fill, reject fifth, drain in order
        base = 40'h1000;
        for (int i = 0; i < DEPTH; i++)
            step("t2.fill", 0,0,0, 1,0, base + 40'(4*i), 32'(i+1), 0, '0);
        chk("t2.full_rdy", 64'(FETCH_READY), 64'd0);
        step("t2.fifth", 0,0,0, 1,0, 40'hBAD0, 32'hBAD, 0, '0);
        chk("t2.occ4", 64'(OCCUPANCY), 64'(DEPTH));
        // full + pop + fetch: fetch still refused
        step("t2.fullpop", 0,0,0, 1,1, 40'hBAD4, 32'hBAD, 0, '0);
        chk("t2.pc_order", 64'(PC_TO_DECODE), 64'(base + 40'd4));
        for (int i = 1; i < DEPTH; i++)
            step("t2.drain", 0,0,0, 0,1, '0, '0, 0, '0);
        chk("t2.empty_val", 64'(DEC_VALID), 64'd0);
        chk("t2.empty_pc",  64'(PC_TO_DECODE), 64'd0);

        // 3: exception entry zeroes the instruction
        step("t3", 0,0,0, 1,0, 40'h4242, 32'hDEADBEEF, 1, 64'h1);
        chk("t3.inst0", 64'(INST_TO_DECODE), 64'd0);
        chk("t3.xcpt",  64'(DEC_XCPT), 64'd1);
        step("t3.drain", 0,0,0, 0,1, '0, '0, 0, '0);

        // 4: lock beats FLUSH_P2, then FLUSH_P2 acts
        for (int i = 0; i < 3; i++)
            step("t4.fill", 0,0,0, 1,0, 40'(40'h2000 + 4*i), 32'(i), 0, '0);
        step("t4.lock", 1,0,1, 1,1, 40'h2100, 32'h1, 0, '0);
        chk("t4.occ3", 64'(OCCUPANCY), 64'd3);
        step("t4.flush2", 0,0,1, 1,1, 40'h2104, 32'h1, 0, '0);
        chk("t4.occ0", 64'(OCCUPANCY), 64'd0);

        // 5: FLUSH_P1 overrides lock
        for (int i = 0; i < 2; i++)
            step("t5.fill", 0,0,0, 1,0, 40'(40'h3000 + 4*i), 32'(i), 0, '0);
        step("t5.flush1", 1,1,0, 1,1, 40'h3100, 32'h1, 0, '0);
        chk("t5.dval", 64'(DEC_VALID), 64'd0);

        // 6: steady push+pop at occupancy 1 with pointer wrap
        step("t6.prime", 0,0,0, 1,0, 40'h5000, 32'h50, 0, '0);
        for (int i = 1; i <= 10; i++) begin
            step("t6.stream", 0,0,0, 1,1, 40'(40'h5000 + 4*i), 32'(80+i), 0, 64'(i));
            chk("t6.pc_seq", 64'(PC_TO_DECODE), 64'(40'h5000 + 40'(4*i)));
        end
        step("t6.more", 0,0,0, 1,0, 40'h6000, 32'h60, 0, '0);
        // asynchronous reset away from any edge
        #2;
        RST = 1'b0;
        #1;
        model_q.delete();
        chk_all("t6.async_rst");
        @(negedge CLK);
        RST = 1'b1;
        idle_inputs();
        @(posedge CLK); #1;

        // Randomized traffic against the reference queue
        for (int n = 0; n < 400; n++) begin
            rpc = {8'h0, $urandom()};
            step("rand",
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) != 0),
                 rpc, 32'($urandom()),
                 ($urandom_range(0, 5) == 0),
                 {32'($urandom()), 32'($urandom())});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
